// File: rtl/aes_scan_driver.sv
// rtl/aes_scan_driver.sv - Serial scan-chain driver for an AES core: shift operands in, await trigger edges, shift result out
module aes_scan_driver #(
  parameter int CHAIN_LEN  = 387,
  parameter int TRIG_COUNT = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [127:0] data_i,
  input  logic [255:0] key_i,
  input  logic         dec_i,
  input  logic         trigger_i,
  input  logic         scan_in,
  output logic         scan_en,
  output logic         scan_out,
  output logic [127:0] data_o,
  output logic         valid_o,
  output logic         err_o,
  output logic         busy_o
);

  localparam int IW = $clog2(CHAIN_LEN);
  localparam int EW = $clog2(TRIG_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_LAST  = IW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] CAP_LIM   = IW'(128);
  localparam logic [EW-1:0] EDGE_LAST = EW'(TRIG_COUNT - 1);
  localparam logic [EW-1:0] EDGE_FULL = EW'(TRIG_COUNT);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WAIT_TRIG,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [EW-1:0]          edge_cnt;
  logic [TW-1:0]          tcnt;
  logic                   trig_prev;
  logic                   trig_rise;
  logic [CHAIN_LEN-1:0]   vec;
  logic [CHAIN_LEN-2:0]   sreg;
  logic [127:0]           cap;

  assign vec       = CHAIN_LEN'({data_i, key_i, 1'b1, 1'b1, dec_i});
  assign trig_rise = trigger_i & ~trig_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      scan_en   <= 1'b0;
      scan_out  <= 1'b0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      idx       <= '0;
      edge_cnt  <= '0;
      tcnt      <= '0;
      trig_prev <= 1'b0;
      sreg      <= '0;
      cap       <= '0;
    end else begin
      trig_prev <= trigger_i;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (load_i) begin
            // vec[0] goes out immediately; the rest waits in the shifter
            scan_out <= vec[0];
            sreg     <= vec[CHAIN_LEN-1:1];
            scan_en  <= 1'b1;
            busy_o   <= 1'b1;
            idx      <= '0;
            state    <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (idx == IDX_LAST) begin
            scan_en  <= 1'b0;
            scan_out <= 1'b0;
            idx      <= '0;
            edge_cnt <= '0;
            tcnt     <= '0;
            state    <= WAIT_TRIG;
          end else begin
            scan_out <= sreg[0];
            sreg     <= sreg >> 1;
            idx      <= idx + IW'(1);
          end
        end
        WAIT_TRIG: begin
          if (trig_rise && edge_cnt == EDGE_LAST) begin
            edge_cnt <= EDGE_FULL;
            scan_en  <= 1'b1;
            idx      <= '0;
            state    <= SHIFT_OUT;
          end else if (tcnt == TO_LAST) begin
            data_o  <= '0;
            valid_o <= 1'b1;
            err_o   <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (trig_rise) edge_cnt <= edge_cnt + EW'(1);
          end
        end
        SHIFT_OUT: begin
          // only the low 128 chain bits carry the result
          if (idx < CAP_LIM) cap[idx[6:0]] <= scan_in;
          if (idx == IDX_LAST) begin
            scan_en <= 1'b0;
            data_o  <= cap;
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          busy_o   <= 1'b0;
          idx      <= '0;
          edge_cnt <= '0;
          tcnt     <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_scan_driver.sv
// tb/tb_aes_scan_driver.sv - Directed self-checking bench for aes_scan_driver
module tb_aes_scan_driver;

  localparam int L  = 387;
  localparam int TO = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_i = 1'b0;
  logic [127:0] data_i = '0;
  logic [255:0] key_i = '0;
  logic         dec_i = 1'b0;
  logic         trigger_i = 1'b0;
  logic         scan_in = 1'b0;
  logic         scan_en;
  logic         scan_out;
  logic [127:0] data_o;
  logic         valid_o;
  logic         err_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  aes_scan_driver dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .data_i(data_i), .key_i(key_i),
    .dec_i(dec_i), .trigger_i(trigger_i), .scan_in(scan_in), .scan_en(scan_en),
    .scan_out(scan_out), .data_o(data_o), .valid_o(valid_o), .err_o(err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid_o === 1'b1) vcount++;

  typedef struct {
    logic [127:0] data;
    logic [255:0] key;
    logic         dec;
    logic [258:0] pat_hi;
    logic [127:0] res;
    bit           bad_load;
    bit           stray;
  } vec_t;

  vec_t tbl[3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic start_load(input vec_t v);
    load_i = 1'b1;
    data_i = v.data;
    key_i  = v.key;
    dec_i  = v.dec;
    tick();
    load_i = 1'b0;
  endtask

  // Entered on the first SHIFT_IN cycle; returns while observing the DONE cycle.
  task automatic run_body(input vec_t v);
    logic [L-1:0]   got;
    logic [L-1:0]   exp;
    logic [L-1:0]   pat;
    logic [127:0]   old;
    int             en_cnt;
    int             so_ones;
    exp = {v.data, v.key, 2'b11, v.dec};
    pat = {v.pat_hi, v.res};
    old = data_o;
    got = '0;
    en_cnt = 0;
    for (int k = 0; k < L; k++) begin
      got[k] = scan_out;
      if (scan_en) en_cnt++;
      if (k == 0) chk("busy_shift_in", busy_o, 1);
      if (v.bad_load && k == 5) begin
        load_i = 1'b1;
        data_i = ~v.data;
        dec_i  = ~v.dec;
      end
      if (v.bad_load && k == 6) load_i = 1'b0;
      if (v.stray) trigger_i = k[1];
      tick();
    end
    trigger_i = 1'b0;
    chk("shift_in_vec", got, exp);
    chk("shift_in_en_cycles", en_cnt, L);
    chk("wait_scan_en", scan_en, 0);
    tick();
    tick();
    trigger_i = 1'b1;
    tick();
    chk("after_edge1_scan_en", scan_en, 0);
    trigger_i = 1'b0;
    tick();
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    en_cnt = 0;
    so_ones = 0;
    for (int k = 0; k < L; k++) begin
      scan_in = pat[k];
      if (scan_en) en_cnt++;
      if (scan_out) so_ones++;
      if (k == 0) chk("shift_out_start", scan_en, 1);
      if (k == L - 1) chk("data_hold", data_o, old);
      tick();
    end
    scan_in = 1'b0;
    chk("shift_out_en_cycles", en_cnt, L);
    chk("shift_out_scan_out", so_ones, 0);
    chk("done_valid", valid_o, 1);
    chk("done_err", err_o, 0);
    chk("done_data", data_o, v.res);
    chk("done_busy", busy_o, 1);
    chk("done_scan_en", scan_en, 0);
  endtask

  initial begin
    int v0;
    int bad;

    tbl[0] = '{128'h00112233445566778899aabbccddeeff, 256'h0, 1'b0,
               {3'b101, 128'h0123456789abcdef0f1e2d3c4b5a6978, 128'h55aa55aa33cc33cc0ff00ff012345678},
               128'hfedcba98765432100123456789abcdef, 1'b0, 1'b0};
    tbl[1] = '{128'hdeadbeefcafef00d0123456789abcdef,
               256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
               {3'b010, 128'hffffffffffffffffffffffffffffffff, 128'h0},
               128'h80000000000000000000000000000001, 1'b1, 1'b0};
    tbl[2] = '{128'hffffffffffffffffffffffffffffffff,
               256'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5aa5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 1'b0,
               {3'b111, 128'h123456789abcdef0fedcba9876543210, 128'hffffffffffffffffffffffffffffffff},
               128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b0, 1'b1};

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_scan_en", scan_en, 0);
    chk("rst_scan_out", scan_out, 0);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      start_load(tbl[i]);
      v0 = vcount;
      if (i == 0) chk("first_scan_en", scan_en, 1);
      run_body(tbl[i]);
      tick();
      chk("idle_busy", busy_o, 0);
      chk("idle_valid", valid_o, 0);
      chk("valid_count", vcount - v0, 1);
    end

    start_load(tbl[2]);
    v0 = vcount;
    for (int k = 0; k < L + 5; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_scan_en", scan_en, 0);
    chk("mid_rst_scan_out", scan_out, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    for (int k = 0; k < 8; k++) begin
      trigger_i = k[0];
      tick();
    end
    trigger_i = 1'b0;
    chk("mid_rst_no_valid", vcount - v0, 0);
    chk("mid_rst_idle", busy_o, 0);

    start_load(tbl[0]);
    v0 = vcount;
    run_body(tbl[0]);
    load_i = 1'b1;
    data_i = tbl[1].data;
    key_i  = tbl[1].key;
    dec_i  = tbl[1].dec;
    tick();
    chk("done_load_ignored", busy_o, 0);
    tick();
    load_i = 1'b0;
    chk("idle_load_accepted", busy_o, 1);
    run_body(tbl[1]);
    tick();
    chk("b2b_valid_count", vcount - v0, 2);

    start_load(tbl[1]);
    v0 = vcount;
    for (int k = 0; k < L; k++) tick();
    chk("to_wait_entry", scan_en, 0);
    bad = 0;
    for (int k = 0; k < TO - 1; k++) begin
      trigger_i = (k == 10);
      if (scan_en || valid_o || err_o) bad++;
      tick();
    end
    trigger_i = 1'b0;
    chk("to_quiet_wait", bad, 0);
    chk("to_not_early", valid_o, 0);
    tick();
    chk("to_valid", valid_o, 1);
    chk("to_err", err_o, 1);
    chk("to_data", data_o, 0);
    chk("to_scan_en", scan_en, 0);
    tick();
    chk("to_idle_busy", busy_o, 0);
    chk("to_err_clear", err_o, 0);
    chk("to_valid_count", vcount - v0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_scan_driver.md
AES_SCAN_DRIVER -- requirements
Module: aes_scan_driver

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 387, meaning scan chain length in bits.
REQ-002 SHALL have parameter TRIG_COUNT, default 2, meaning trigger rising edges that mark end of operation.
REQ-003 SHALL have parameter TIMEOUT, default 1000, meaning maximum cycles spent in WAIT_TRIG.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port load_i  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port data_i  input  128  plaintext/ciphertext operand.
REQ-008 SHALL have port key_i  input  256  key operand.
REQ-009 SHALL have port dec_i  input  1  1 = decrypt, 0 = encrypt.
REQ-010 SHALL have port trigger_i  input  1  core trigger, already synchronous to clk.
REQ-011 SHALL have port scan_in  input  1  serial data returned from core scan chain.
REQ-012 SHALL have port scan_en  output  1  scan shift enable to core.
REQ-013 SHALL have port scan_out  output  1  serial data driven into core scan chain.
REQ-014 SHALL have port data_o  output  128  captured result.
REQ-015 SHALL have port valid_o  output  1  one-cycle result strobe.
REQ-016 SHALL have port err_o  output  1  one-cycle timeout strobe, coincident with valid_o.
REQ-017 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, SHIFT_IN, WAIT_TRIG, SHIFT_OUT, DONE.
REQ-019 SHALL, in IDLE with load_i=1 at cycle N, latch vec = {data_i, key_i, 1'b1, 1'b1, dec_i} (bits 386..0) and enter SHIFT_IN at N+1.
REQ-020 SHALL, in SHIFT_IN, hold scan_en=1 for exactly CHAIN_LEN cycles and drive vec LSB first (cycle k drives vec[k], k=0..CHAIN_LEN-1), then enter WAIT_TRIG.
REQ-021 SHALL, in WAIT_TRIG, hold scan_en=0 and scan_out=0, and count rising edges of trigger_i (trigger_i=1 with its previous-cycle value 0).
REQ-022 SHALL ignore trigger_i edges outside WAIT_TRIG; the edge detector's previous-value register SHALL update every cycle.
REQ-023 SHALL leave WAIT_TRIG for SHIFT_OUT on the cycle after the TRIG_COUNT-th edge.
REQ-024 SHALL, if TIMEOUT cycles elapse in WAIT_TRIG without reaching TRIG_COUNT edges, enter DONE with an error flag set and skip SHIFT_OUT.
REQ-025 SHALL, in SHIFT_OUT, hold scan_en=1 for CHAIN_LEN cycles, drive scan_out=0, and store scan_in on shift cycle k into cap[k].
REQ-026 SHALL, on SHIFT_OUT exit, load data_o = cap[127:0] and enter DONE.
REQ-027 SHALL, in DONE, pulse valid_o for one cycle, pulse err_o in the same cycle only on timeout, then return to IDLE.
REQ-028 SHALL, on timeout, load data_o = 0.
REQ-029 SHALL hold data_o stable from DONE until the next DONE.
REQ-030 SHALL ignore load_i while busy_o=1; such a request is neither queued nor accepted later.
REQ-031 SHALL accept load_i again in the first IDLE cycle after DONE.
REQ-032 SHALL wrap no counter: the shift index counts 0..CHAIN_LEN-1, the edge counter saturates at TRIG_COUNT, and the timeout counter clears on WAIT_TRIG entry.

Reset
REQ-033 SHALL, with rst_n=0 at a rising edge, set state=IDLE, scan_en=0, scan_out=0, data_o=0, valid_o=0, err_o=0, busy_o=0, and all counters to 0, on the following cycle.
REQ-034 SHALL treat reset asserted mid-operation in any state as REQ-033, aborting the operation without a valid_o pulse.
REQ-035 SHALL give rst_n priority over a simultaneous load_i.

Verification
REQ-036 Nominal: load_i=1 at cycle N, data_i=128'h00112233445566778899aabbccddeeff, key_i=0, dec_i=0 -> scan_en high N+1..N+387; first three scan_out bits 0,1,1; then bits of key (all 0), then data_i LSB first.
REQ-037 Completion: two trigger_i pulses in WAIT_TRIG, scan_in model returns a known 387-bit pattern -> data_o = pattern[127:0], valid_o=1 for exactly one cycle, err_o=0, busy_o=0 the cycle after.
REQ-038 Timeout: no trigger_i in WAIT_TRIG -> after 1000 cycles, valid_o=1 and err_o=1 together, data_o=0, no SHIFT_OUT (scan_en stays 0).
REQ-039 Ignored load: load_i pulsed during SHIFT_IN with different data_i -> shifted vector unchanged, exactly one valid_o for the whole run.
REQ-040 Reset mid-operation: rst_n=0 for one cycle during WAIT_TRIG -> all outputs 0 next cycle, no valid_o, new load_i accepted afterwards.
REQ-041 Stray trigger: trigger_i edges during SHIFT_IN are not counted -> two further edges in WAIT_TRIG are still required before SHIFT_OUT.
